// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed big-endian byte image over
// valid/ready, writes 16-bit words into instruction memory, and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] data_in,
    output logic              we,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t state, next_state;

    logic [7:0]        len_hi;
    logic [15:0]       length;
    logic [15:0]       len_full;
    logic [7:0]        word_hi;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_inc;
    logic              xfer;

    assign xfer      = byte_valid & byte_ready;
    assign len_full  = {len_hi, byte_in};
    assign index_inc = index + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) next_state = LEN_HI;
            LEN_HI:          if (xfer) next_state = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == '0)                    next_state = DONE;
                    else if (len_full > 16'(MAX_WORDS))    next_state = ERR;
                    else                                   next_state = DATA_HI;
                end
            end
            DATA_HI:         if (xfer) next_state = DATA_LO;
            DATA_LO:         if (xfer) next_state = WRITE;
            WRITE: begin
                if (index_inc == ADDR_W'(length)) next_state = DONE;
                else                              next_state = DATA_HI;
            end
            default:         next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

    // waddr/data_in load as the low byte lands so they are valid throughout WRITE and hold afterwards.
    // cpu_rst follows next_state so it drops on the same edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi  <= '0;
            length  <= '0;
            word_hi <= '0;
            index   <= '0;
            waddr   <= '0;
            data_in <= '0;
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= (next_state != DONE);
            unique case (state)
                IDLE, DONE, ERR: if (start) index <= '0;
                LEN_HI:          if (xfer) len_hi <= byte_in;
                LEN_LO:          if (xfer) length <= len_full;
                DATA_HI:         if (xfer) word_hi <= byte_in;
                DATA_LO: begin
                    if (xfer) begin
                        waddr   <= index;
                        data_in <= DATA_W'({word_hi, byte_in});
                    end
                end
                WRITE:           index <= index_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized images and
// handshake gaps, checked against an image-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] waddr;
    logic [15:0] data_in;
    logic        we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [7:0] img[$];

    imem_loader #(.ADDR_W(16), .DATA_W(16), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .waddr(waddr),
        .data_in(data_in), .we(we), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string ctx);
        chk({ctx, "_cpu_rst"}, 32'(cpu_rst), 1);
        chk({ctx, "_we"}, 32'(we), 0);
        chk({ctx, "_waddr"}, 32'(waddr), 0);
        chk({ctx, "_data_in"}, 32'(data_in), 0);
        chk({ctx, "_byte_ready"}, 32'(byte_ready), 0);
        chk({ctx, "_busy"}, 32'(busy), 0);
        chk({ctx, "_done"}, 32'(done), 0);
        chk({ctx, "_err"}, 32'(err), 0);
    endtask

    task automatic make_image(input int n);
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        if (n <= 1024)
            for (int k = 0; k < 2 * n; k++) img.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_cpu_rst", 32'(cpu_rst), 1);
        chk("start_done", 32'(done), 0);
        chk("start_err", 32'(err), 0);
        chk("start_ready", 32'(byte_ready), 1);
    endtask

    // Drives img from the current position; called at a negedge after pulse_start.
    // stop_bytes >= 0 abandons the load once that many bytes have transferred.
    task automatic run_load(input int gap_pct, input bit mid_starts, input int stop_bytes);
        logic [31:0] expq[$];
        logic [31:0] e;
        int  n, pos, cyc, last_we, budget, used;
        bit  exp_err, finished, rdy;
        n        = int'({img[0], img[1]});
        exp_err  = (n > 1024);
        pos      = 0;
        cyc      = 0;
        last_we  = -1;
        finished = 0;
        budget   = 50 + 8 * img.size();
        if (!exp_err)
            for (int k = 0; k < n; k++)
                expq.push_back({16'(k), img[2 + 2 * k], img[3 + 2 * k]});
        while (cyc < budget) begin
            if (we) begin
                if (expq.size() == 0) chk("extra_we", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("waddr", 32'(waddr), 32'(e[31:16]));
                    chk("data_in", 32'(data_in), 32'(e[15:0]));
                end
                chk("ready_in_write", 32'(byte_ready), 0);
                if (gap_pct == 0 && last_we >= 0) chk("we_spacing", 32'(cyc - last_we), 3);
                last_we = cyc;
            end
            if (done || err || (stop_bytes >= 0 && pos == stop_bytes)) begin
                finished = 1;
                break;
            end
            byte_valid = (pos < img.size()) && ($urandom_range(99) >= gap_pct);
            byte_in    = (pos < img.size()) ? img[pos] : 8'($urandom);
            start      = mid_starts && ($urandom_range(3) == 0);
            rdy        = byte_ready;
            @(posedge clk);
            if (byte_valid && rdy) pos++;
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (!finished) chk("timeout", 0, 1);
        else if (stop_bytes < 0) begin
            used = exp_err ? 2 : 2 + 2 * n;
            chk("end_done", 32'(done), 32'(!exp_err));
            chk("end_err", 32'(err), 32'(exp_err));
            chk("end_cpu_rst", 32'(cpu_rst), 32'(exp_err));
            chk("end_busy", 32'(busy), 0);
            chk("missing_we", 32'(expq.size()), 0);
            chk("bytes_used", 32'(pos), 32'(used));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        #13;
        check_reset_vals("in_rst");
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no start.
        repeat (10) @(negedge clk);
        byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("idle");
        byte_valid = 1'b0;

        // Fixed three-word image, valid held high.
        img = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        pulse_start();
        run_load(0, 0, -1);

        // Empty image.
        make_image(0);
        pulse_start();
        run_load(0, 0, -1);

        // Oversized header, then recovery with a valid image.
        img = {8'h04, 8'h01};
        pulse_start();
        run_load(0, 0, -1);
        repeat (5) @(negedge clk);
        chk("err_hold", 32'(err), 1);
        chk("err_hold_cpu_rst", 32'(cpu_rst), 1);
        make_image(5);
        pulse_start();
        run_load(30, 0, -1);

        // Fixed image again with random gaps and ignored mid-load starts.
        img = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        pulse_start();
        run_load(50, 1, -1);

        // Asynchronous reset after the second word's high byte.
        pulse_start();
        run_load(0, 0, 5);
        chk("pre_rst_data_in", 32'(data_in), 32'h1234);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("post_rst");
        make_image(4);
        pulse_start();
        run_load(20, 1, -1);

        // Largest accepted image and far-oversized header.
        make_image(1024);
        pulse_start();
        run_load(0, 0, -1);
        make_image(16'hFFFF);
        pulse_start();
        run_load(0, 0, -1);

        // Random images with random gaps and stray starts.
        for (int t = 0; t < 6; t++) begin
            make_image(int'($urandom_range(40, 1)));
            pulse_start();
            run_load(int'($urandom_range(60)), 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
